// File: rtl/shift_sequencer.sv
// Sequencer for an external shift register: loads a word, applies 0..7 single-bit
// shifts in one direction, captures the result and offers it over a valid/ready port.
module shift_sequencer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [2:0]        cmd_amount,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              sr_shift_left,
    output logic              sr_shift_right,
    output logic [DATA_W-1:0] sr_parallel_in,
    input  logic [DATA_W-1:0] sr_parallel_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [7:0]        done_count
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DONE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                dir_q, dir_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [DONE_W-1:0]   done_q, done_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                shl_q, shl_d;
    logic                shr_q, shr_d;

    // Next-state, datapath and next-output decode; outputs follow the next state
    // so every port is driven straight from a flop.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        done_d     = done_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    data_d  = cmd_data;
                    cnt_d   = cmd_amount;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = (cnt_q != CNT_W'(0)) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rsp_data_d = sr_parallel_out;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    done_d  = done_q + DONE_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
        shl_d       = (state_d == SHIFT) && !dir_d;
        shr_d       = (state_d == SHIFT) && dir_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            done_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            shl_q       <= 1'b0;
            shr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign done_count     = done_q;
    assign sr_shift_left  = shl_q;
    assign sr_shift_right = shr_q;
    assign sr_parallel_in = data_q;

endmodule
